// File: rtl/sap1_prog_loader.sv
// Streams a program image into the 16x8 SAP-1 memory, optionally verifies a trailing
// two's-complement checksum, and holds the CPU in reset until the image is good.
module sap1_prog_loader #(
   parameter int AW          = 4,
   parameter int DW          = 8,
   parameter int CHECKSUM_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          START,
   input  logic          IN_VALID,
   input  logic [DW-1:0] IN_DATA,
   output logic          IN_READY,
   input  logic [AW-1:0] ADDR,
   input  logic          CE,
   output logic [DW-1:0] DATA_OUT,
   output logic          CPU_RST,
   output logic          DONE,
   output logic          ERR,
   output logic [AW-1:0] LOAD_ADDR
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CSUM = 3'd2,
      S_RUN  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

   state_t        state_r;
   state_t        state_s;
   logic [AW-1:0] ptr_r;
   logic [DW-1:0] sum_r;
   logic [DW-1:0] mem_r [2**AW];
   logic          xfer_s;
   logic          reload_s;
   logic          csum_ok_s;

   // A valid image sums to zero including its checksum byte.
   function automatic logic [DW-1:0] csum_of(input logic [DW-1:0] sum);
      return {DW{1'b0}} - sum;
   endfunction

   assign xfer_s    = IN_VALID & IN_READY;
   assign reload_s  = START & ((state_r == S_IDLE) | (state_r == S_RUN) | (state_r == S_ERR));
   assign csum_ok_s = (IN_DATA == csum_of(sum_r));
   assign LOAD_ADDR = ptr_r;
   assign DATA_OUT  = CE ? {DW{1'b0}} : mem_r[ADDR];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; START is only honoured outside the streaming states.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE, S_RUN, S_ERR: begin
            if (START) begin
               state_s = S_LOAD;
            end else begin
               state_s = state_r;
            end
         end
         S_LOAD: begin
            if (xfer_s && (ptr_r == PTR_LAST)) begin
               state_s = (CHECKSUM_EN != 0) ? S_CSUM : S_RUN;
            end else begin
               state_s = S_LOAD;
            end
         end
         S_CSUM: begin
            if (xfer_s) begin
               state_s = csum_ok_s ? S_RUN : S_ERR;
            end else begin
               state_s = S_CSUM;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      IN_READY = 1'b0;
      CPU_RST  = 1'b1;
      DONE     = 1'b0;
      ERR      = 1'b0;
      case (state_r)
         S_LOAD, S_CSUM: IN_READY = 1'b1;
         S_RUN: begin
            CPU_RST = 1'b0;
            DONE    = 1'b1;
         end
         S_ERR:   ERR = 1'b1;
         default: IN_READY = 1'b0;
      endcase
   end

   // Write pointer and running sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {AW{1'b0}};
         sum_r <= {DW{1'b0}};
      end else if (reload_s) begin
         ptr_r <= {AW{1'b0}};
         sum_r <= {DW{1'b0}};
      end else if (xfer_s && (state_r == S_LOAD)) begin
         ptr_r <= ptr_r + AW'(1);
         sum_r <= sum_r + IN_DATA;
      end else begin
         ptr_r <= ptr_r;
         sum_r <= sum_r;
      end
   end

   // Image memory; the checksum byte is never stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
      end else if (xfer_s && (state_r == S_LOAD)) begin
         mem_r[ptr_r] <= IN_DATA;
      end else begin
         mem_r[ptr_r] <= mem_r[ptr_r];
      end
   end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed bench for sap1_prog_loader: one instance with checksum, one without.
module tb_sap1_prog_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       start_a = 1'b0, valid_a = 1'b0, ready_a, ce_a = 1'b1;
   logic [7:0] data_a = 8'h00, dout_a;
   logic [3:0] addr_a = 4'h0, laddr_a;
   logic       cpu_rst_a, done_a, err_a;

   logic       start_b = 1'b0, valid_b = 1'b0, ready_b, ce_b = 1'b1;
   logic [7:0] data_b = 8'h00, dout_b;
   logic [3:0] addr_b = 4'h0, laddr_b;
   logic       cpu_rst_b, done_b, err_b;

   int tests = 0;
   int fails = 0;
   int xfers = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [7:0]  img [16];

   always #5 clk = ~clk;

   sap1_prog_loader #(.AW(4), .DW(8), .CHECKSUM_EN(1)) dut_a (
      .clk(clk), .rst(rst), .START(start_a), .IN_VALID(valid_a), .IN_DATA(data_a),
      .IN_READY(ready_a), .ADDR(addr_a), .CE(ce_a), .DATA_OUT(dout_a),
      .CPU_RST(cpu_rst_a), .DONE(done_a), .ERR(err_a), .LOAD_ADDR(laddr_a));

   sap1_prog_loader #(.AW(4), .DW(8), .CHECKSUM_EN(0)) dut_b (
      .clk(clk), .rst(rst), .START(start_b), .IN_VALID(valid_b), .IN_DATA(data_b),
      .IN_READY(ready_b), .ADDR(addr_b), .CE(ce_b), .DATA_OUT(dout_b),
      .CPU_RST(cpu_rst_b), .DONE(done_b), .ERR(err_b), .LOAD_ADDR(laddr_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL sb_empty: got %0h with no expected value", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", t, obs, e);
         end
      end
   endtask

   task automatic send(input bit which, input logic [7:0] b);
      int n = 0;
      if (which) begin valid_b = 1'b1; data_b = b; end
      else begin valid_a = 1'b1; data_a = b; end
      while (((which ? ready_b : ready_a) !== 1'b1) && n < 50) begin
         tick();
         n++;
      end
      tests++;
      assert (n < 50) else begin
         fails++;
         $error("FAIL send_timeout: got %0d waits expected <50", n);
      end
      tick();
      xfers++;
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   task automatic rd_a(input string tag, input logic [3:0] a, input logic [7:0] e);
      push(tag, {24'h0, e});
      addr_a = a;
      ce_a   = 1'b0;
      #1;
      chk({24'h0, dout_a});
   endtask

   task automatic load_img(input logic [7:0] csum);
      for (int i = 0; i < 16; i++) send(1'b0, img[i]);
      send(1'b0, csum);
   endtask

   task automatic kick_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      img = '{8'h09, 8'h1A, 8'h1B, 8'h2B, 8'hE0, 8'hF0, 8'hFF, 8'hFF,
              8'hFF, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

      // 1. reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("rst_cpu_rst", 32'd1);  chk({31'h0, cpu_rst_a});
      push("rst_in_ready", 32'd0); chk({31'h0, ready_a});
      push("rst_done", 32'd0);     chk({31'h0, done_a});
      push("rst_err", 32'd0);      chk({31'h0, err_a});
      push("rst_load_addr", 32'd0); chk({28'h0, laddr_a});
      rd_a("rst_dout", 4'd5, 8'h00);

      // 2. nominal load
      kick_a();
      push("load_ready", 32'd1); chk({31'h0, ready_a});
      xfers = 0;
      load_img(8'hC8);
      push("nom_xfers", 32'd17);  chk(xfers);
      push("nom_done", 32'd1);    chk({31'h0, done_a});
      push("nom_cpu_rst", 32'd0); chk({31'h0, cpu_rst_a});
      push("nom_ready", 32'd0);   chk({31'h0, ready_a});
      rd_a("nom_mem1", 4'd1, 8'h1A);
      rd_a("nom_mem9", 4'd9, 8'h01);
      push("nom_ce_hi", 32'd0);
      ce_a = 1'b1;
      #1;
      chk({24'h0, dout_a});

      // 3. bad checksum
      kick_a();
      load_img(8'hC7);
      push("bad_err", 32'd1);     chk({31'h0, err_a});
      push("bad_done", 32'd0);    chk({31'h0, done_a});
      push("bad_cpu_rst", 32'd1); chk({31'h0, cpu_rst_a});
      rd_a("bad_mem11", 4'd11, 8'h03);
      kick_a();
      push("err_clear", 32'd0);  chk({31'h0, err_a});
      push("err_ready", 32'd1);  chk({31'h0, ready_a});
      push("err_laddr", 32'd0);  chk({28'h0, laddr_a});

      // 4. gaps and ignored START while streaming
      for (int i = 0; i < 16; i++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
         push("gap_laddr", i);
         chk({28'h0, laddr_a});
         send(1'b0, img[i]);
         if (i == 4) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            push("start_ignored_laddr", 32'd5);
            chk({28'h0, laddr_a});
         end
      end
      tick();
      send(1'b0, 8'hC8);
      push("gap_done", 32'd1); chk({31'h0, done_a});
      for (int i = 0; i < 16; i++) rd_a("gap_mem", 4'(i), img[i]);

      // 5. reset mid-load
      kick_a();
      for (int i = 0; i < 7; i++) send(1'b0, img[i]);
      push("mid_laddr7", 32'd7); chk({28'h0, laddr_a});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("mid_laddr", 32'd0);   chk({28'h0, laddr_a});
      push("mid_cpu_rst", 32'd1); chk({31'h0, cpu_rst_a});
      push("mid_ready", 32'd0);   chk({31'h0, ready_a});
      for (int i = 0; i < 16; i++) rd_a("mid_mem_zero", 4'(i), 8'h00);
      tick();
      kick_a();
      load_img(8'hC8);
      push("mid_reload_done", 32'd1); chk({31'h0, done_a});
      rd_a("mid_reload_mem0", 4'd0, 8'h09);

      // 6. no checksum instance
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 16; i++) send(1'b1, img[i]);
      push("nocs_done", 32'd1);    chk({31'h0, done_b});
      push("nocs_cpu_rst", 32'd0); chk({31'h0, cpu_rst_b});
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      push("nocs_restart_cpu_rst", 32'd1); chk({31'h0, cpu_rst_b});
      push("nocs_restart_done", 32'd0);    chk({31'h0, done_b});
      for (int i = 0; i < 16; i++) send(1'b1, 8'h55);
      push("nocs_reload_done", 32'd1); chk({31'h0, done_b});
      push("nocs_err", 32'd0);         chk({31'h0, err_b});
      push("nocs_mem0", 32'h55);
      addr_b = 4'd0;
      ce_b   = 1'b0;
      #1;
      chk({24'h0, dout_b});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sap1_prog_loader.md
Name: sap1_prog_loader

Overview:
Program writer for the 16x8 SAP-1 program/data memory: the write-side counterpart of the CPU's fetch/read path. It accepts a byte stream over a valid/ready handshake, writes it sequentially into the memory, and optionally checks a trailing two's-complement checksum. It holds the CPU in reset until the image is loaded and verified. It replaces the hard-coded memory image and gives the CPU its active-low-CE combinational read port.

Parameters:
AW, 4, address width; memory depth is 2**AW (16)
DW, 8, data width
CHECKSUM_EN, 1, 1 = expect one checksum byte after the image; 0 = no checksum

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
START  in  1  begin a load (level sampled each clock)
IN_VALID  in  1  IN_DATA valid
IN_DATA  in  DW  stream byte
IN_READY  out  1  loader accepts a byte this cycle
ADDR  in  AW  CPU read address (from MAR)
CE  in  1  CPU read enable, active-low
DATA_OUT  out  DW  mem[ADDR] when CE=0, else 0
CPU_RST  out  1  CPU reset hold, high except in RUN
DONE  out  1  image loaded and verified; CPU running
ERR  out  1  checksum mismatch
LOAD_ADDR  out  AW  current write pointer

Behaviour:
- All outputs are registered or state-decoded except DATA_OUT, which is combinational.
- States: IDLE, LOAD, CSUM, RUN, ERR.
- Transfer: a byte is accepted on a rising edge when IN_VALID=1 and IN_READY=1. IN_READY=1 exactly in LOAD and CSUM.
- Reset (rst=1 at an edge, any state, including mid-load):
  - state=IDLE, all memory words=0, LOAD_ADDR=0, running sum=0.
  - CPU_RST=1, IN_READY=0, DONE=0, ERR=0.
- IDLE: START=1 -> LOAD; ptr=0, sum=0.
- LOAD, on each transfer:
  - mem[ptr]<=IN_DATA
  - sum<=(sum+IN_DATA) mod 2**DW
  - ptr<=ptr+1, wrapping
- LOAD exit: on the transfer at ptr=2**AW-1, go to CSUM if CHECKSUM_EN=1, else RUN. ptr wraps to 0.
- CSUM: on the transfer, if IN_DATA == (-sum) mod 2**DW go to RUN, else go to ERR. The checksum byte is not written to memory.
- RUN:
  - CPU_RST=0, DONE=1, IN_READY=0.
  - The first cycle with state=RUN shows CPU_RST=0, i.e. the edge after the last transfer.
  - START=1 -> LOAD; CPU_RST=1 and DONE=0 from the next cycle. The old image stays in memory until overwritten.
- ERR:
  - CPU_RST=1, ERR=1, DONE=0. Memory is retained.
  - START=1 -> LOAD with ERR=0.
- START in LOAD or CSUM is ignored; there is no restart mid-stream.
- IN_VALID in IDLE, RUN or ERR causes no write and no state change.
- Read port:
  - DATA_OUT = mem[ADDR] if CE=0, else 0. Valid in every state.
  - A same-cycle read and write to the same address returns the old data; the new data appears after the edge.
- LOAD_ADDR = ptr. It advances only on transfers and holds during IN_VALID gaps.

Test Plan:
1. Reset: rst=1 for one edge, then CE=0, ADDR=5 -> CPU_RST=1, IN_READY=0, DONE=0, ERR=0, LOAD_ADDR=0, DATA_OUT=00.
2. Nominal load: START, then back-to-back bytes 09,1A,1B,2B,E0,F0,FF,FF,FF,01,02,03,FF,FF,FF,FF plus checksum C8.
   - Expect 17 transfers.
   - On the edge after C8: DONE=1, CPU_RST=0.
   - ADDR=1, CE=0 -> 1A; ADDR=9 -> 01; CE=1 -> 00.
3. Bad checksum: same image with checksum C7.
   - Expect ERR=1, DONE=0, CPU_RST=1; mem[11] reads 03.
   - Then START=1 -> next cycle ERR=0, IN_READY=1, LOAD_ADDR=0.
4. Backpressure and gaps: IN_VALID toggled pseudo-randomly, with START=1 pulsed after the 5th byte.
   - START is ignored.
   - LOAD_ADDR increments only on transfers.
   - Final contents and DONE match scenario 2.
5. Reset mid-load: rst=1 after 7 transfers.
   - Expect IDLE, LOAD_ADDR=0, mem[0..15]=00, CPU_RST=1, IN_READY=0.
   - A subsequent full load succeeds.
6. CHECKSUM_EN=0: 16 bytes -> RUN on the edge after the 16th byte.
   - START in RUN -> CPU_RST=1 the next cycle.
   - Reloading all bytes as 55 gives mem[0]=55 and DONE=1.
